// File: rtl/cnn_ctrl_pkg.sv
// rtl/cnn_ctrl_pkg.sv - shared state type and default widths for the cnn run controller
package cnn_ctrl_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 72;
   localparam int DEF_RES_W  = 8;
   localparam int DEF_TO_W   = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      START,
      RUN
   } ctrl_state_e;

endpackage

// File: rtl/cnn_run_timer.sv
// rtl/cnn_run_timer.sv - RUN-phase watchdog counter for cnn_run_ctrl
// expired is raised in the cycle the count steps onto all-ones.
module cnn_run_timer #(
   parameter int TO_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam logic [TO_W-1:0] TERM = {{(TO_W-1){1'b1}}, 1'b0};

   logic [TO_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = en && (cnt_q == TERM);

endmodule

// File: rtl/cnn_run_ctrl.sv
// rtl/cnn_run_ctrl.sv - weight load / start / result capture sequencer for the cnn core
// Optional RUN watchdog enabled by defining CNN_RUN_CTRL_TIMEOUT_EN.
module cnn_run_ctrl
   import cnn_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RES_W  = DEF_RES_W,
   parameter int TO_W   = DEF_TO_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_start,
   input  logic              cfg_abort,
   input  logic [ADDR_W-1:0] cfg_num_words,
   input  logic              wt_valid,
   output logic              wt_ready,
   input  logic [DATA_W-1:0] wt_data,
   output logic              write_en,
   output logic [ADDR_W-1:0] addr_w,
   output logic [DATA_W-1:0] data_w,
   output logic              sta,
   input  logic              valid_o,
   input  logic [RES_W-1:0]  data1_i,
   input  logic [RES_W-1:0]  data2_i,
   output logic [RES_W-1:0]  data1_out,
   output logic [RES_W-1:0]  data2_out,
   output logic              busy,
   output logic              done,
   output logic              timeout_err
);

   ctrl_state_e       state_q, state_d;
   logic [ADDR_W-1:0] num_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              start_acc;
   logic              wt_hs;
   logic              capture;
   logic              timer_expired;

   assign wt_ready = (state_q == LOAD) && (cnt_q < num_q);
   assign busy     = (state_q != IDLE);

   // Abort outranks everything, so no handshake, capture or start is taken with it.
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      wt_hs     = 1'b0;
      capture   = 1'b0;
      if (cfg_abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (cfg_start) begin
                  start_acc = 1'b1;
                  state_d   = (cfg_num_words == '0) ? START : LOAD;
               end
            end
            LOAD: begin
               if (wt_valid && wt_ready) begin
                  wt_hs = 1'b1;
                  if (cnt_q == num_q - 1'b1) state_d = START;
               end
            end
            START: state_d = RUN;
            RUN: begin
               if (valid_o) begin
                  capture = 1'b1;
                  state_d = IDLE;
               end else if (timer_expired) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         num_q     <= '0;
         cnt_q     <= '0;
         write_en  <= 1'b0;
         addr_w    <= '0;
         data_w    <= '0;
         sta       <= 1'b0;
         done      <= 1'b0;
         data1_out <= '0;
         data2_out <= '0;
      end else begin
         state_q  <= state_d;
         write_en <= wt_hs;
         sta      <= (state_d == START);
         done     <= capture;
         if (start_acc) begin
            num_q <= cfg_num_words;
            cnt_q <= '0;
         end
         if (wt_hs) begin
            addr_w <= cnt_q;
            data_w <= wt_data;
            cnt_q  <= cnt_q + 1'b1;
         end
         if (capture) begin
            data1_out <= data1_i;
            data2_out <= data2_i;
         end
      end
   end

`ifdef CNN_RUN_CTRL_TIMEOUT_EN
   logic timeout_err_q;

   cnn_run_timer #(
      .TO_W(TO_W)
   ) u_run_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state_q != RUN),
      .en     (state_q == RUN),
      .expired(timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_err_q <= 1'b0;
      end else if (start_acc) begin
         timeout_err_q <= 1'b0;
      end else if ((state_q == RUN) && !cfg_abort && !valid_o && timer_expired) begin
         timeout_err_q <= 1'b1;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   logic [TO_W-1:0] to_unused;

   assign to_unused     = '0;
   assign timer_expired = 1'b0;
   assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_run_ctrl.sv
// tb/tb_cnn_run_ctrl.sv - randomized self-checking bench for cnn_run_ctrl
module tb_cnn_run_ctrl;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 72;
   localparam int RES_W  = 8;
   localparam int TO_W   = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_start, cfg_abort;
   logic [ADDR_W-1:0] cfg_num_words;
   logic              wt_valid, wt_ready;
   logic [DATA_W-1:0] wt_data;
   logic              write_en;
   logic [ADDR_W-1:0] addr_w;
   logic [DATA_W-1:0] data_w;
   logic              sta, valid_o;
   logic [RES_W-1:0]  data1_i, data2_i, data1_out, data2_out;
   logic              busy, done, timeout_err;

   int total = 0;
   int bad   = 0;
   logic [RES_W-1:0] exp_d1 = '0;
   logic [RES_W-1:0] exp_d2 = '0;

   always #5 clk = ~clk;

   cnn_run_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W), .TO_W(TO_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .cfg_num_words(cfg_num_words), .wt_valid(wt_valid), .wt_ready(wt_ready),
      .wt_data(wt_data), .write_en(write_en), .addr_w(addr_w), .data_w(data_w),
      .sta(sta), .valid_o(valid_o), .data1_i(data1_i), .data2_i(data2_i),
      .data1_out(data1_out), .data2_out(data2_out), .busy(busy), .done(done),
      .timeout_err(timeout_err)
   );

   task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // vmode 0 = wt_valid toggles 1,0,1,0...; otherwise percent chance of wt_valid per cycle
   task automatic run_job(input int num, input int vmode, input int lat,
                          input logic [RES_W-1:0] d1, input logic [RES_W-1:0] d2);
      logic [DATA_W-1:0] words[$];
      logic [DATA_W-1:0] w;
      int fed = 0;
      int wr = 0;
      int cyc = 0;
      bit sta_seen = 0;
      bit hs_prev = 0;
      for (int i = 0; i < num; i++) begin
         w[31:0]  = $urandom();
         w[63:32] = $urandom();
         w[71:64] = 8'($urandom());
         words.push_back(w);
      end
      cfg_num_words = ADDR_W'(num);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      check("busy_on", busy, 1);
      check("to_clr", timeout_err, 0);
      while (!sta_seen && cyc < 40 * num + 50) begin
         check("wr_en", write_en, hs_prev);
         if (write_en) begin
            if (wr < num) begin
               check("addr", addr_w, wr);
               check("data", data_w, words[wr]);
            end else begin
               check("extra_wr", wr, num);
            end
            wr++;
         end
         if (sta) begin
            sta_seen = 1;
            check("sta_after_last", wr, num);
            if (num == 0) check("sta_lat0", cyc, 0);
            else check("sta_with_last", write_en, 1);
         end else begin
            check("wt_ready", wt_ready, fed < num);
         end
         if (vmode == 0) wt_valid = (cyc % 2 == 0);
         else wt_valid = ($urandom_range(0, 99) < vmode);
         wt_data = (fed < num) ? words[fed] : '0;
         hs_prev = wt_valid && wt_ready;
         if (hs_prev) fed++;
         @(negedge clk);
         cyc++;
      end
      check("sta_seen", sta_seen, 1);
      wt_valid = 1'b0;
      for (int k = 0; k < lat; k++) begin
         check("run_quiet", {sta, done, write_en, busy}, 4'b0001);
         check("hold1", data1_out, exp_d1);
         data1_i = 8'($urandom());
         data2_i = 8'($urandom());
         @(negedge clk);
      end
      check("run_sta_once", sta, 0);
      valid_o = 1'b1;
      data1_i = d1;
      data2_i = d2;
      exp_d1 = d1;
      exp_d2 = d2;
      @(negedge clk);
      valid_o = 1'b0;
      data1_i = 8'($urandom());
      check("done", done, 1);
      check("d1", data1_out, exp_d1);
      check("d2", data2_out, exp_d2);
      check("busy_off", busy, 0);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("d1_hold", data1_out, exp_d1);
   endtask

   task automatic abort_test();
      cfg_num_words = ADDR_W'(5);
      cfg_start = 1'b1;
      wt_valid = 1'b1;
      wt_data = {8'h11, 64'h0};
      @(negedge clk);
      cfg_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_pre_wr", {write_en, addr_w}, {1'b1, 10'd1});
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
      check("abort_idle", {busy, write_en, sta, done}, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("abort_quiet", {busy, write_en, sta, done, wt_ready}, 5'b00000);
         check("abort_hold", data1_out, exp_d1);
      end
      wt_valid = 1'b0;
   endtask

   task automatic reset_test();
      cfg_num_words = '0;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      exp_d1 = '0;
      exp_d2 = '0;
      check("rst_ctl", {busy, done, sta, write_en, wt_ready, timeout_err}, 6'b0);
      check("rst_d1", data1_out, exp_d1);
      check("rst_d2", data2_out, exp_d2);
      check("rst_addr", addr_w, 0);
      check("rst_data", data_w, 0);
      @(negedge clk);
      rst_n = 1'b1;
      valid_o = 1'b1;
      data1_i = 8'h77;
      data2_i = 8'h88;
      @(negedge clk);
      valid_o = 1'b0;
      check("post_rst_d1", data1_out, exp_d1);
      check("post_rst_done", {done, busy}, 2'b00);
   endtask

   initial begin
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      cfg_num_words = '0;
      wt_valid = 1'b0;
      wt_data = '0;
      valid_o = 1'b0;
      data1_i = '0;
      data2_i = '0;
      repeat (2) @(negedge clk);
      check("reset_ctl", {busy, done, sta, write_en, wt_ready, timeout_err}, 6'b0);
      check("reset_res", {data1_out, data2_out}, 16'h0);
      rst_n = 1'b1;
      @(negedge clk);

      run_job(3, 100, 2, 8'h5A, 8'hA5);
      run_job(4, 0, 3, 8'h3C, 8'hC3);
      run_job(0, 100, 4, 8'h12, 8'h34);
      abort_test();
      run_job(3, 100, 1, 8'h01, 8'h02);
      for (int j = 0; j < 15; j++) begin
         run_job($urandom_range(0, 7), $urandom_range(25, 100), $urandom_range(0, 8),
                 8'($urandom()), 8'($urandom()));
      end
      run_job(1023, 100, 1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
      reset_test();

`ifdef CNN_RUN_CTRL_TIMEOUT_EN
      begin
         int runc = 0;
         cfg_num_words = '0;
         cfg_start = 1'b1;
         @(negedge clk);
         cfg_start = 1'b0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            runc++;
         end
         check("to_cycles", runc, 15);
         check("to_err", timeout_err, 1);
         check("to_nodone", done, 0);
         check("to_hold", data1_out, exp_d1);
         @(negedge clk);
         check("to_sticky", timeout_err, 1);
         run_job(1, 100, 2, 8'h9A, 8'h9B);
      end
`else
      check("to_tied", timeout_err, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
